// File: rtl/ldst_pkg.sv
// Shared definitions for the L1 load/store fill path: default widths and the
// fill engine state encoding.
package ldst_pkg;

   localparam int LDST_DATA_WIDTH = 32;
   localparam int LDST_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_e;

endpackage : ldst_pkg

// File: rtl/ldst_hold_reg.sv
// One-entry valid/ready holding stage between the global-memory source and the
// L1 write port. A new word can be accepted in the same cycle the held word is
// written, so a continuous stream moves at one word per cycle with no bubbles.
module ldst_hold_reg
   import ldst_pkg::*;
#(
   parameter int DATA_WIDTH = LDST_DATA_WIDTH,
   parameter int ADDR_WIDTH = LDST_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  load;
   logic                  write;

   // Handshake and next-entry computation: load wins over drain, which keeps
   // the entry full when a write and a new word coincide.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      valid_d  = valid_q;
      addr_d   = addr_q;
      data_d   = data_q;
      in_ready = !valid_q || out_ready;
      load     = in_valid && in_ready;
      write    = valid_q && out_ready;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = in_addr;
         data_d  = in_data;
      end else if (write) begin
         valid_d = 1'b0;
      end
   end

   // Entry register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of block ordering.
      if (rst) begin
         // NOTE: address/data are reset too (not just valid) because they
         // drive the L1 port directly and must read zero out of reset.
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_addr  = addr_q;
   assign out_data  = data_q;

endmodule : ldst_hold_reg

// File: rtl/l1_fill_ctrl.sv
// L1 fill engine: accepts a (base, len) request, streams len words from global
// memory into consecutive L1 word addresses (wrapping), yields the shared L1
// write port to SP stores (st_busy), and pulses done once per completed fill.
module l1_fill_ctrl
   import ldst_pkg::*;
#(
   parameter int DATA_WIDTH = LDST_DATA_WIDTH,
   parameter int ADDR_WIDTH = LDST_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_base,
   input  logic [ADDR_WIDTH:0]   req_len,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [DATA_WIDTH-1:0] src_data,
   input  logic                  st_busy,
   output logic                  lwe_gs,
   output logic [ADDR_WIDTH-1:0] addr_gs,
   output logic [DATA_WIDTH-1:0] ldata_gs,
   output logic                  busy,
   output logic                  done
);

   localparam int LW = ADDR_WIDTH + 1;
   // A request can cover at most the whole L1 once.
   localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

   fill_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q,  base_d;
   logic [LW-1:0]         len_q,   len_d;
   logic [LW-1:0]         cnt_q,   cnt_d;

   logic                  hold_in_valid;
   logic                  hold_in_ready;
   logic                  hold_valid;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [LW-1:0]         len_clamped;
   logic                  src_accept;
   logic                  last_word;

   // Destination of the next accepted word; the truncating add gives the
   // wrap from the top of L1 back to address 0.
   assign word_addr   = base_q + cnt_q[ADDR_WIDTH-1:0];
   assign len_clamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;
   assign last_word   = (cnt_q == (len_q - LW'(1)));

   ldst_hold_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (hold_in_valid),
      .in_ready  (hold_in_ready),
      .in_addr   (word_addr),
      .in_data   (src_data),
      .out_valid (hold_valid),
      .out_ready (!st_busy),
      .out_addr  (addr_gs),
      .out_data  (ldata_gs)
   );

   // Next-state and handshake outputs; control outputs are forced low while
   // rst is asserted so an abort takes effect in the reset cycle itself.
   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      req_ready     = (state_q == ST_IDLE) && !rst;
      hold_in_valid = (state_q == ST_FILL) && src_valid && !rst;
      src_ready     = (state_q == ST_FILL) && hold_in_ready && !rst;
      src_accept    = src_valid && src_ready;
      lwe_gs        = hold_valid && !st_busy && !rst;
      busy          = (state_q != ST_IDLE) && !rst;
      done          = (state_q == ST_DONE) && !rst;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               base_d  = req_base;
               len_d   = len_clamped;
               cnt_d   = '0;
               state_d = (len_clamped == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (src_accept) begin
               cnt_d = cnt_q + LW'(1);
               if (last_word) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Leave as soon as the final held word is written this cycle.
            if (!hold_valid || lwe_gs) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Engine state and request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule : l1_fill_ctrl

// File: tb/tb_l1_fill_ctrl.sv
// Scoreboard bench for l1_fill_ctrl. The monitor builds the expected L1 write
// sequence from each accepted request (base + i wrapping, clamped length,
// words in offer order) and checks every observed write, done pulse and the
// busy/req_ready state against it.
module tb_l1_fill_ctrl;
   import ldst_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_base = '0;
   logic [AW:0]   req_len = '0;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [DW-1:0] src_data = '0;
   logic          st_busy = 1'b0;
   logic          lwe_gs;
   logic [AW-1:0] addr_gs;
   logic [DW-1:0] ldata_gs;
   logic          busy;
   logic          done;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   logic [DW-1:0] cur_words[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            exp_done = 0;
   bit            in_flight = 1'b0;
   int            req_wr_cnt = 0;
   int            last_wr_cyc = 0;
   int            cyc = 0;

   always #5 clk = ~clk;

   l1_fill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_base  (req_base),
      .req_len   (req_len),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_data  (src_data),
      .st_busy   (st_busy),
      .lwe_gs    (lwe_gs),
      .addr_gs   (addr_gs),
      .ldata_gs  (ldata_gs),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired or event not allowed (cycle %0d)", name, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard.
   wr_t mon_w;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_done  = 0;
         in_flight = 1'b0;
      end else begin
         check("busy", busy, in_flight);
         check("req_ready", req_ready, !in_flight);
         if (st_busy) check("stall_no_write", lwe_gs, 1'b0);
         if (lwe_gs) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required (cycle %0d)",
                        addr_gs, ldata_gs, cyc);
            end else begin
               mon_w = exp_q.pop_front();
               check("wr_addr", addr_gs, mon_w.addr);
               check("wr_data", ldata_gs, mon_w.data);
               req_wr_cnt++;
               last_wr_cyc = cyc;
            end
         end
         if (done) begin
            if (exp_done == 0) begin
               flag("unexpected_done");
            end else begin
               exp_done--;
               check("writes_before_done", exp_q.size(), 0);
               if (req_wr_cnt > 0) check("done_latency", cyc - last_wr_cyc, 1);
            end
            in_flight = 1'b0;
         end
         if (req_valid && req_ready) begin
            int len_eff;
            len_eff = (int'(req_len) > DEPTH) ? DEPTH : int'(req_len);
            for (int i = 0; i < len_eff; i++) begin
               wr_t w;
               w.addr = AW'(int'(req_base) + i);
               w.data = cur_words[i];
               exp_q.push_back(w);
            end
            exp_done++;
            in_flight   = 1'b1;
            req_wr_cnt  = 0;
            last_wr_cyc = 0;
         end
      end
   end

   // vmode: 0 always valid, 1 toggling, 2 random. smode: 0 none, 1 random
   // stalls, 2 three stall cycles once the first word is written.
   task automatic run_req(input logic [AW-1:0] base, input int len, input int vmode,
                          input int smode, input int abort_after);
      int  len_eff;
      int  idx;
      int  budget;
      int  stall_left;
      bit  tog;
      bit  accepted;
      bit  do_chk;
      bit  got;
      len_eff = (len > DEPTH) ? DEPTH : len;
      cur_words.delete();
      for (int i = 0; i < len_eff; i++) cur_words.push_back($urandom);
      req_base  = base;
      req_len   = (AW+1)'(len);
      req_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (!got) begin
         flag("req_accept_timeout");
         return;
      end
      idx = 0;
      budget = len_eff * 10 + 100;
      stall_left = 3;
      tog = 1'b1;
      while (idx < len_eff && budget > 0) begin
         case (vmode)
            0:       src_valid = 1'b1;
            1:       src_valid = tog;
            default: src_valid = 1'($urandom_range(0, 1));
         endcase
         tog = ~tog;
         src_data = cur_words[idx];
         do_chk = 1'b0;
         case (smode)
            1:       st_busy = ($urandom_range(0, 3) == 0);
            2: begin
               st_busy = (req_wr_cnt == 1) && (stall_left > 0);
               if (st_busy) begin
                  stall_left--;
                  do_chk = 1'b1;
               end
            end
            default: st_busy = 1'b0;
         endcase
         @(negedge clk);
         if (do_chk) begin
            check("stall_lwe_low", lwe_gs, 1'b0);
            check("stall_addr_held", addr_gs, AW'(int'(base) + 1));
         end
         accepted = src_valid && src_ready;
         if (accepted) idx++;
         @(posedge clk); #1;
         budget--;
         if (abort_after >= 0 && accepted && idx == abort_after) begin
            check("abort_writes_so_far", req_wr_cnt, abort_after - 1);
            rst = 1'b1;
            src_valid = 1'b0;
            st_busy = 1'b0;
            @(negedge clk);
            check("abort_lwe_low", lwe_gs, 1'b0);
            check("abort_no_done", done, 1'b0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (4) begin
               @(posedge clk); #1;
            end
            return;
         end
      end
      src_valid = 1'b0;
      if (idx < len_eff) flag("src_stream_timeout");
      budget = 200;
      while (in_flight && budget > 0) begin
         st_busy = (smode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(posedge clk); #1;
         budget--;
      end
      st_busy = 1'b0;
      if (in_flight) flag("done_timeout");
      check("all_written", exp_q.size(), 0);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_src_ready", src_ready, 1'b0);
      check("rst_lwe_gs", lwe_gs, 1'b0);
      check("rst_addr_gs", addr_gs, '0);
      check("rst_ldata_gs", ldata_gs, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_req(10'h010, 4, 0, 0, -1);   // straight four-word fill
      run_req(10'h3FE, 4, 0, 0, -1);   // address wrap
      run_req(10'h010, 4, 0, 2, -1);   // three-cycle stall on second word
      run_req(10'h123, 0, 0, 0, -1);   // empty request
      run_req(10'h040, 8, 1, 0, -1);   // toggling source
      run_req(10'h080, 6, 0, 0, 2);    // reset after two words
      run_req(10'h0A0, 5, 0, 0, -1);   // clean restart after abort
      run_req(AW'($urandom), 1500, 2, 1, -1);  // length clamps to full L1
      for (int r = 0; r < 30; r++) begin
         run_req(AW'($urandom), $urandom_range(0, 20), 2, 1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_l1_fill_ctrl
